// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register carrying control and data bundles.
// Updates on the falling clock edge. An optional skid slot lets in_ready_o come from a flop.
module pipe_stage_reg #(
    parameter int unsigned       DATA_W   = 128,
    parameter int unsigned       CTRL_W   = 16,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
    parameter bit                SKID     = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o
);

    logic              main_valid_q, main_valid_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;

    logic              skid_valid_q;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [DATA_W-1:0] skid_data_q;

    logic accept;
    logic deliver;

    assign accept  = in_valid_i & in_ready_o;
    assign deliver = main_valid_q & out_ready_i;

    // Main slot refills from skid first so beats keep arrival order.
    always_comb begin
        main_valid_d = main_valid_q;
        main_ctrl_d  = main_ctrl_q;
        main_data_d  = main_data_q;
        if (!main_valid_q || deliver) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = skid_ctrl_q;
                main_data_d  = skid_data_q;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_ctrl_d  = in_ctrl_i;
                main_data_d  = in_data_i;
            end else begin
                main_valid_d = 1'b0;
                main_ctrl_d  = CTRL_NOP;
            end
        end
        if (flush_i) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = CTRL_NOP;
            main_data_d  = main_data_q;
        end
    end

    always_ff @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            main_valid_q <= 1'b0;
            main_ctrl_q  <= CTRL_NOP;
            main_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_ctrl_q  <= main_ctrl_d;
            main_data_q  <= main_data_d;
        end
    end

    if (SKID) begin : g_skid
        logic              skid_valid_d;
        logic [CTRL_W-1:0] skid_ctrl_d;
        logic [DATA_W-1:0] skid_data_d;

        // Skid only catches a beat that arrives while main is full and stalled.
        always_comb begin
            skid_valid_d = skid_valid_q;
            skid_ctrl_d  = skid_ctrl_q;
            skid_data_d  = skid_data_q;
            if (skid_valid_q && deliver) begin
                skid_valid_d = 1'b0;
            end else if (main_valid_q && !deliver && accept) begin
                skid_valid_d = 1'b1;
                skid_ctrl_d  = in_ctrl_i;
                skid_data_d  = in_data_i;
            end
            if (flush_i) begin
                skid_valid_d = 1'b0;
            end
        end

        always_ff @(negedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                skid_valid_q <= 1'b0;
                skid_ctrl_q  <= CTRL_NOP;
                skid_data_q  <= '0;
            end else begin
                skid_valid_q <= skid_valid_d;
                skid_ctrl_q  <= skid_ctrl_d;
                skid_data_q  <= skid_data_d;
            end
        end

        assign in_ready_o = ~skid_valid_q;
    end else begin : g_no_skid
        assign skid_valid_q = 1'b0;
        assign skid_ctrl_q  = CTRL_NOP;
        assign skid_data_q  = '0;
        assign in_ready_o   = ~main_valid_q | out_ready_i;
    end

    assign out_valid_o = main_valid_q;
    assign out_ctrl_o  = main_ctrl_q;
    assign out_data_o  = main_data_q;
    assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 (index 1) and SKID=0 (index 0) instances share stimulus,
// each checked against a FIFO-of-beats model with a capacity of 2 or 1.
module tb_pipe_stage_reg;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic [15:0]  in_ctrl;
    logic [127:0] in_data;
    logic         out_ready;
    logic         flush;

    logic         rdy[2];
    logic         vld[2];
    logic [15:0]  ctl[2];
    logic [127:0] dat[2];
    logic [1:0]   occ[2];

    int n_cmp = 0;
    int n_bad = 0;

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .CTRL_NOP(16'h0000), .SKID(1'b1)) u_skid (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .flush_i(flush), .out_valid_o(vld[1]),
        .out_ready_i(out_ready), .out_ctrl_o(ctl[1]), .out_data_o(dat[1]),
        .occupancy_o(occ[1])
    );

    pipe_stage_reg #(.DATA_W(128), .CTRL_W(16), .CTRL_NOP(16'h0000), .SKID(1'b0)) u_flat (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
        .in_ctrl_i(in_ctrl), .in_data_i(in_data), .flush_i(flush), .out_valid_o(vld[0]),
        .out_ready_i(out_ready), .out_ctrl_o(ctl[0]), .out_data_o(dat[0]),
        .occupancy_o(occ[0])
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    // Model: per instance, an ordered list of held beats plus the last value main showed.
    typedef struct packed {
        logic [15:0]  c;
        logic [127:0] d;
    } beat_t;

    beat_t        st[2][2];
    int           cnt[2]  = '{0, 0};
    logic [127:0] hold[2] = '{128'd0, 128'd0};

    function automatic logic exp_rdy(input int k);
        if (k == 1) return cnt[k] < 2;
        return (cnt[k] == 0) || out_ready;
    endfunction

    initial begin
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                for (int k = 0; k < 2; k++) begin
                    cnt[k]  = 0;
                    hold[k] = '0;
                end
            end else begin
                for (int k = 0; k < 2; k++) begin
                    logic r, del, acc;
                    r   = exp_rdy(k);
                    del = (cnt[k] > 0) && out_ready;
                    acc = in_valid && r;
                    if (del) begin
                        st[k][0] = st[k][1];
                        cnt[k]   = cnt[k] - 1;
                    end
                    if (acc) begin
                        st[k][cnt[k]] = {in_ctrl, in_data};
                        cnt[k]        = cnt[k] + 1;
                    end
                    if (flush) cnt[k] = 0;
                    else if (cnt[k] > 0) hold[k] = st[k][0].d;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare on the rising edge, half a period away from the active falling edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                for (int k = 0; k < 2; k++) begin
                    chk($sformatf("u%0d.out_valid", k), 128'(vld[k]), 128'(cnt[k] > 0));
                    chk($sformatf("u%0d.out_ctrl", k), 128'(ctl[k]),
                        (cnt[k] > 0) ? 128'(st[k][0].c) : 128'd0);
                    chk($sformatf("u%0d.out_data", k), dat[k],
                        (cnt[k] > 0) ? st[k][0].d : hold[k]);
                    chk($sformatf("u%0d.occupancy", k), 128'(occ[k]), 128'(cnt[k]));
                    chk($sformatf("u%0d.in_ready", k), 128'(rdy[k]), 128'(exp_rdy(k)));
                end
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] c, input logic [127:0] d,
                        input logic ordy, input logic fl);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ctrl = '0; in_data = '0;
        out_ready = 1'b0; flush = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst.out_valid", 128'(vld[k]), 128'd0);
            chk("rst.out_ctrl", 128'(ctl[k]), 128'd0);
            chk("rst.out_data", dat[k], 128'd0);
            chk("rst.occupancy", 128'(occ[k]), 128'd0);
            chk("rst.in_ready", 128'(rdy[k]), 128'd1);
        end
        #1 reset = 1'b0;

        // Reset mid-stream acts without a clock edge.
        step(1'b1, 16'h00A5, 128'd1, 1'b0, 1'b0);
        chk("mid.loaded_valid", 128'(vld[1]), 128'd1);
        chk("mid.loaded_ctrl", 128'(ctl[1]), 128'h00A5);
        in_valid = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("mid.out_valid", 128'(vld[1]), 128'd0);
        chk("mid.out_ctrl", 128'(ctl[1]), 128'd0);
        chk("mid.out_data", dat[1], 128'd0);
        chk("mid.occupancy", 128'(occ[1]), 128'd0);
        chk("mid.u0_out_data", dat[0], 128'd0);
        #1 reset = 1'b0;

        // Streaming with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 16'(i + 256), 128'(i), 1'b1, 1'b0);
            chk($sformatf("stream.u1_data%0d", i), dat[1], 128'(i));
            chk($sformatf("stream.u1_occ%0d", i), 128'(occ[1]), 128'd1);
            chk($sformatf("stream.u1_rdy%0d", i), 128'(rdy[1]), 128'd1);
            chk($sformatf("stream.u0_data%0d", i), dat[0], 128'(i));
        end
        step(1'b0, 16'h0, 128'd0, 1'b1, 1'b0);
        chk("bubble.out_valid", 128'(vld[1]), 128'd0);
        chk("bubble.out_ctrl", 128'(ctl[1]), 128'd0);
        chk("bubble.out_data", dat[1], 128'd8);
        chk("bubble.u0_out_data", dat[0], 128'd8);

        // Stall fills main and skid, then drains in order.
        step(1'b1, 16'h0010, 128'd10, 1'b0, 1'b0);
        step(1'b1, 16'h0011, 128'd11, 1'b0, 1'b0);
        step(1'b1, 16'h0012, 128'd12, 1'b0, 1'b0);
        chk("stall.occupancy", 128'(occ[1]), 128'd2);
        chk("stall.in_ready", 128'(rdy[1]), 128'd0);
        chk("stall.out_data", dat[1], 128'd10);
        step(1'b1, 16'h0012, 128'd12, 1'b1, 1'b0);
        chk("drain.data11", dat[1], 128'd11);
        chk("drain.in_ready", 128'(rdy[1]), 128'd1);
        step(1'b1, 16'h0012, 128'd12, 1'b1, 1'b0);
        chk("drain.data12", dat[1], 128'd12);
        step(1'b0, 16'h0, 128'd0, 1'b1, 1'b0);
        chk("drain.empty", 128'(vld[1]), 128'd0);

        // Flush with a full stage drops everything including the incoming beat.
        step(1'b1, 16'h0020, 128'd20, 1'b0, 1'b0);
        step(1'b1, 16'h0021, 128'd21, 1'b0, 1'b0);
        step(1'b1, 16'h0022, 128'd22, 1'b0, 1'b1);
        chk("flush.out_valid", 128'(vld[1]), 128'd0);
        chk("flush.out_ctrl", 128'(ctl[1]), 128'd0);
        chk("flush.occupancy", 128'(occ[1]), 128'd0);
        chk("flush.in_ready", 128'(rdy[1]), 128'd1);
        chk("flush.out_data_held", dat[1], 128'd20);
        step(1'b1, 16'h0023, 128'd23, 1'b0, 1'b0);
        chk("flush.next_valid", 128'(vld[1]), 128'd1);
        chk("flush.next_data", dat[1], 128'd23);
        // Flush with deliver and an acceptable incoming beat.
        step(1'b1, 16'h0024, 128'd24, 1'b1, 1'b1);
        chk("flush2.u1_occ", 128'(occ[1]), 128'd0);
        chk("flush2.u1_data", dat[1], 128'd23);
        chk("flush2.u0_occ", 128'(occ[0]), 128'd0);

        // Combinational in_ready of the single-register build.
        step(1'b1, 16'h0030, 128'd30, 1'b0, 1'b0);
        in_valid = 1'b1; in_ctrl = 16'h0031; in_data = 128'd31; out_ready = 1'b0;
        #1;
        chk("flat.stalled_rdy", 128'(rdy[0]), 128'd0);
        out_ready = 1'b1;
        #1;
        chk("flat.released_rdy", 128'(rdy[0]), 128'd1);
        @(posedge clk);
        #1;
        chk("flat.replaced_data", dat[0], 128'd31);
        chk("flat.replaced_valid", 128'(vld[0]), 128'd1);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, 16'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
        end
        step(1'b0, 16'h0, 128'd0, 1'b1, 1'b0);
        step(1'b0, 16'h0, 128'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register. It supersedes the hand-written per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle between stages with a valid/ready elastic handshake.
- An optional skid slot absorbs one beat when downstream stalls, so in_ready comes straight from a flop.
- Flush turns the stage into a bubble: a NOP control word with out_valid low.

Parameters:
- DATA_W, 128, width of data bundle (nextpc, reg data1/data2, sign-extended imm).
- CTRL_W, 16, width of control bundle (reg_write, mem_read, alu_op, ...).
- CTRL_NOP, 0, control value driven during bubble, reset and flush.
- SKID, 1, 1 = two-entry (main + skid) elastic stage; 0 = single register, combinational in_ready.

Ports:
- clk  input  1  stage clock; all state updates on falling edge (pipeline-register convention of this processor).
- reset  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this edge.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  DATA_W  upstream data bundle.
- flush  input  1  kill all held beats and any incoming beat (branch taken / hazard squash).
- out_valid  output  1  downstream beat present.
- out_ready  input  1  downstream accepts beat this edge.
- out_ctrl  output  CTRL_W  control bundle; equals CTRL_NOP whenever out_valid=0.
- out_data  output  DATA_W  data bundle; holds last value when out_valid=0.
- occupancy  output  2  number of held beats (0..2; max 1 when SKID=0).

Behaviour:

Reset (async, immediate, mid-operation included):
- main_valid=0, skid_valid=0, out_ctrl=CTRL_NOP, out_data=0, occupancy=0.
- in_ready=1 (SKID=1); in_ready=1 per its equation (SKID=0).

Handshake:
- Accept = in_valid & in_ready at falling edge.
- Deliver = out_valid & out_ready at falling edge.
- Latency: 1 edge from accept to out_valid when the stage is empty.
- Beats leave in arrival order; no duplication; no loss except by flush.

SKID=1:
- in_ready = ~skid_valid (registered, no path from out_ready).
- Empty, accept -> main loaded, out_valid=1 next.
- Main full, deliver & accept -> main replaced by new beat.
- Main full, no deliver, accept -> beat goes to skid; in_ready=0 next.
- Main+skid full, deliver -> main<=skid, skid empty, in_ready=1 next. No accept this edge, since in_ready=0.
- Main full, deliver, no accept -> out_valid=0, out_ctrl=CTRL_NOP next.

SKID=0:
- in_ready = ~main_valid | out_ready (combinational).
- Accept loads main, same rules otherwise.

Flush (synchronous, at falling edge):
- Priority over reset-free events. Clears main_valid and skid_valid, forces out_ctrl=CTRL_NOP, out_data held.
- A beat presented on the same edge is dropped even if in_ready=1.
- A simultaneous deliver still counts downstream (downstream saw valid before the edge).
- After flush: occupancy=0, in_ready=1.

Other rules:
- occupancy = main_valid + skid_valid, updated on the same edge as the state.
- Inputs are ignored when in_ready=0: no state change from in_ctrl/in_data.
- Control/data bundles are opaque: no arithmetic, no width conversion; bit order preserved.

Test Plan:
- Reset mid-stream: load beat ctrl=16'h00A5, data=1, then assert reset between edges -> out_valid=0, out_ctrl=0, out_data=0, occupancy=0 immediately, without waiting for a clk edge.
- Streaming with out_ready=1: beats data=1..8 back-to-back -> out_data 1..8 on consecutive edges, 1-edge latency, in_ready stays 1, occupancy stays 1.
- Stall with SKID=1: send data=10,11,12 with out_ready=0 -> 10 in main, 11 in skid, in_ready=0, 12 held upstream, occupancy=2. Then out_ready=1 -> outputs 10,11,12 in order.
- Flush with full stage: main=20, skid=21, in_valid with 22 on the flush edge -> out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1. Beat 22 never appears; next beat 23 arrives after 1 edge.
- SKID=0 build: out_valid=1, out_ready=0 -> in_ready=0. Raise out_ready -> in_ready=1 in the same cycle, and the replacement beat is delivered next edge.
- Bubble content: after last beat drains with no new input -> out_valid=0, out_ctrl=CTRL_NOP (0), out_data equals last delivered value.
